// File: rtl/des_sbox_seq_if.sv
// Handshake/bus bundle between the DES round datapath and the S-box sequencer.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready on the input word and out_valid/out_ready on the result.
//
// Signals:
//   in_valid/in_ready/in_data    48-bit expanded, key-mixed word (bit 1 = MSB)
//   sbox_sel/sbox_in/sbox_out    shared 6-to-4 S-box bank lookup port
//   out_valid/out_ready/out_data 32-bit substitution result (bit 1 = MSB)
//   busy                         sequencer is not idle
interface des_sbox_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:48] in_data;
  logic [2:0]  sbox_sel;
  logic [1:6]  sbox_in;
  logic [1:4]  sbox_out;
  logic        out_valid;
  logic        out_ready;
  logic [1:32] out_data;
  logic        busy;

  // Environment side: upstream producer, downstream consumer and S-box bank.
  modport master (
    output in_valid, in_data, sbox_out, out_ready,
    input  in_ready, sbox_sel, sbox_in, out_valid, out_data, busy
  );

  // Sequencer side.
  modport slave (
    input  in_valid, in_data, sbox_out, out_ready,
    output in_ready, sbox_sel, sbox_in, out_valid, out_data, busy
  );
endinterface

// File: rtl/des_sbox_seq.sv
// Time-shares one external 6-to-4 S-box bank across all eight DES S-boxes for one 48-bit word.
// Latency: result valid 9 cycles after accept (LOOKUP_LAT=0) or 10 cycles (LOOKUP_LAT=1).
// Backpressure: one word in flight; in_ready stays low until the result is taken by out_ready.
//
// Ports:
//   clk, rst  rising-edge clock, asynchronous active-high reset
//   bus       des_sbox_seq_if.slave: input word handshake, bank lookup port, result handshake, busy
//   abort     (only when DES_SBOX_SEQ_ABORT_EN is defined) drops the current transaction
//
// Parameter LOOKUP_LAT: 0 = combinational bank, 1 = registered bank. Other values do not elaborate.
// Optional feature macro: DES_SBOX_SEQ_ABORT_EN.
module des_sbox_seq #(
  parameter int LOOKUP_LAT = 0
) (
  input  logic          clk,
  input  logic          rst,
`ifdef DES_SBOX_SEQ_ABORT_EN
  input  logic          abort,
`endif
  des_sbox_seq_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:48] hold_q;    // word captured on accept; ISSUE reads only this copy
  logic [2:0]  cnt_q;     // issue counter, doubles as the S-box select
  logic [1:32] out_q;     // result assembly register
  logic        rdy_en_q;  // keeps in_ready low until the first edge after reset

  logic        in_ready;
  logic        out_valid;
  logic        busy;
  logic        accept;
  logic        abort_act;
  logic        cap_en;    // write sbox_out into nibble cap_idx this cycle
  logic [2:0]  cap_idx;

  // Only a combinational or a single-register bank is supported.
  if (LOOKUP_LAT != 0 && LOOKUP_LAT != 1) begin : g_bad_lat
    $error("des_sbox_seq: LOOKUP_LAT must be 0 or 1");
  end

  assign accept = bus.in_valid && in_ready;

`ifdef DES_SBOX_SEQ_ABORT_EN
  // Abort is meaningless with nothing in flight.
  assign abort_act = abort && (state_q != S_IDLE);
`else
  assign abort_act = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;

    case (state_q)
      S_IDLE: begin
        in_ready = rdy_en_q;
        busy     = 1'b0;
        if (accept) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cnt_q == 3'd7) begin
          // A registered bank still owes the S8 result one cycle later.
          state_d = (LOOKUP_LAT == 1) ? S_DRAIN : S_DONE;
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over everything, including a simultaneous out_ready in DONE.
    if (abort_act) begin
      state_d = S_IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // Result capture alignment
  // ---------------------------------------------------------------------------
  if (LOOKUP_LAT == 1) begin : g_lat1
    logic       iss_vld_q;
    logic [2:0] iss_idx_q;

    // The bank answers one cycle after the address, so remember which nibble
    // was asked for and whether the cycle was a real issue.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        iss_vld_q <= 1'b0;
        iss_idx_q <= 3'd0;
      end else begin
        iss_vld_q <= (state_q == S_ISSUE) && !abort_act;
        iss_idx_q <= cnt_q;
      end
    end

    assign cap_en  = iss_vld_q;
    assign cap_idx = iss_idx_q;
  end else begin : g_lat0
    // Combinational bank: the answer belongs to the chunk issued this cycle.
    assign cap_en  = (state_q == S_ISSUE);
    assign cap_idx = cnt_q;
  end

  // ---------------------------------------------------------------------------
  // State, holding register, counter and result
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      hold_q   <= '0;
      cnt_q    <= 3'd0;
      out_q    <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;

      if (abort_act) begin
        // Partial nibbles must never be seen as a result.
        out_q <= '0;
      end else if (accept) begin
        hold_q <= bus.in_data;
        cnt_q  <= 3'd0;
        out_q  <= '0;
      end else begin
        // Counter parks on 7 so sbox_sel keeps its last value after ISSUE.
        if (state_q == S_ISSUE && cnt_q != 3'd7) begin
          cnt_q <= cnt_q + 3'd1;
        end
        if (cap_en) begin
          out_q[4 * int'(cap_idx) + 1 +: 4] <= bus.sbox_out;
        end
      end
    end
  end

  // sbox_sel/sbox_in come straight from registered state, so they hold the
  // last issued chunk outside ISSUE and read 0 after reset.
  assign bus.sbox_sel  = cnt_q;
  assign bus.sbox_in   = hold_q[6 * int'(cnt_q) + 1 +: 6];
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_q;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_des_sbox_seq.sv
// Bench for des_sbox_seq: runs a LOOKUP_LAT=0 and a LOOKUP_LAT=1 instance side by side,
// each with its own standard DES S-box bank, and compares against a table-driven
// DES substitution model plus the known all-zeros / all-ones results.
module tb_des_sbox_seq;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Standard DES S-boxes: entry [4*s + row] holds the 16 columns, column 0 in the top nibble.
  logic [63:0] rows [0:31] = '{
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
  };

  // Row is the outer two bits of the 6-bit input, column the middle four.
  function automatic logic [3:0] sb(input logic [2:0] s, input logic [5:0] x);
    logic [63:0] r;
    int row, col;
    row = int'({x[5], x[0]});
    col = int'(x[4:1]);
    r   = rows[int'(s) * 4 + row];
    return r[63 - 4 * col -: 4];
  endfunction

  // Reference: full DES substitution of a 48-bit word, S1 on the top six bits.
  function automatic logic [31:0] ref_sub(input logic [47:0] w);
    logic [31:0] res;
    res = '0;
    for (int k = 0; k < 8; k++) begin
      res[31 - 4 * k -: 4] = sb(3'(k), w[47 - 6 * k -: 6]);
    end
    return res;
  endfunction

  function automatic logic [47:0] rnd48();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[47:0];
  endfunction

  // Per-instance drive/observe arrays: index 0 = LOOKUP_LAT 0, index 1 = LOOKUP_LAT 1.
  logic        iv   [2];
  logic [47:0] id   [2];
  logic        ordy [2];
  logic        ir   [2];
  logic        ov   [2];
  logic [31:0] od   [2];
  logic [2:0]  sel  [2];
  logic [5:0]  sin  [2];
  logic        bsy  [2];
`ifdef DES_SBOX_SEQ_ABORT_EN
  logic        abort_s [2];
`endif

  des_sbox_seq_if bus0 ();
  des_sbox_seq_if bus1 ();

  des_sbox_seq #(.LOOKUP_LAT(0)) u_lat0 (
    .clk   (clk),
    .rst   (rst),
`ifdef DES_SBOX_SEQ_ABORT_EN
    .abort (abort_s[0]),
`endif
    .bus   (bus0)
  );

  des_sbox_seq #(.LOOKUP_LAT(1)) u_lat1 (
    .clk   (clk),
    .rst   (rst),
`ifdef DES_SBOX_SEQ_ABORT_EN
    .abort (abort_s[1]),
`endif
    .bus   (bus1)
  );

  assign bus0.in_valid  = iv[0];
  assign bus0.in_data   = id[0];
  assign bus0.out_ready = ordy[0];
  assign bus1.in_valid  = iv[1];
  assign bus1.in_data   = id[1];
  assign bus1.out_ready = ordy[1];

  assign ir[0]  = bus0.in_ready;
  assign ov[0]  = bus0.out_valid;
  assign od[0]  = bus0.out_data;
  assign sel[0] = bus0.sbox_sel;
  assign sin[0] = bus0.sbox_in;
  assign bsy[0] = bus0.busy;
  assign ir[1]  = bus1.in_ready;
  assign ov[1]  = bus1.out_valid;
  assign od[1]  = bus1.out_data;
  assign sel[1] = bus1.sbox_sel;
  assign sin[1] = bus1.sbox_in;
  assign bsy[1] = bus1.busy;

  // S-box banks: combinational for instance 0, one register stage for instance 1.
  assign bus0.sbox_out = sb(bus0.sbox_sel, bus0.sbox_in);
  always_ff @(posedge clk) bus1.sbox_out <= sb(bus1.sbox_sel, bus1.sbox_in);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string ph);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_in_ready%0d", ph, d), ir[d], 0);
      chk($sformatf("%s_out_valid%0d", ph, d), ov[d], 0);
      chk($sformatf("%s_out_data%0d", ph, d), od[d], 0);
      chk($sformatf("%s_sbox_sel%0d", ph, d), sel[d], 0);
      chk($sformatf("%s_sbox_in%0d", ph, d), sin[d], 0);
      chk($sformatf("%s_busy%0d", ph, d), bsy[d], 0);
    end
  endtask

  // One word through both instances. Accept is cycle t (the negedge where in_valid is raised);
  // loop index k is cycle t+k. bp = cycles out_ready is withheld once out_valid is up.
  // stress keeps in_valid high with junk data while busy.
  task automatic txn(input logic [47:0] w, input logic [31:0] exp, input int bp, input bit stress);
    bit done [2];
    int hs   [2];
    int first;
    done = '{0, 0};
    hs   = '{0, 0};
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("idle_rdy%0d", d), ir[d], 1);
      iv[d]   = 1'b1;
      id[d]   = w;
      ordy[d] = 1'b0;
    end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        first = 9 + d;
        if (!done[d]) begin
          iv[d] = stress;
          id[d] = rnd48();
          if (k == 1) chk($sformatf("cleared%0d", d), od[d], 0);
          if (k <= 8) begin
            chk($sformatf("sel%0d_k%0d", d, k), sel[d], 64'(k - 1));
            chk($sformatf("sin%0d_k%0d", d, k), sin[d], w[47 - 6 * (k - 1) -: 6]);
          end
          chk($sformatf("busy_rdy%0d_k%0d", d, k), ir[d], 0);
          chk($sformatf("busy%0d_k%0d", d, k), bsy[d], 1);
          if (k < first) begin
            chk($sformatf("early_valid%0d_k%0d", d, k), ov[d], 0);
          end else begin
            chk($sformatf("valid%0d_k%0d", d, k), ov[d], 1);
            chk($sformatf("data%0d_k%0d", d, k), od[d], exp);
            if (k - first >= bp) begin
              ordy[d] = 1'b1;
              iv[d]   = 1'b0;
              done[d] = 1'b1;
              hs[d]   = k;
            end
          end
        end else if (k == hs[d] + 1) begin
          chk($sformatf("post_rdy%0d", d), ir[d], 1);
          chk($sformatf("post_valid%0d", d), ov[d], 0);
          chk($sformatf("post_busy%0d", d), bsy[d], 0);
          ordy[d] = 1'b0;
        end
      end
      if (done[0] && done[1] && k > hs[0] && k > hs[1]) break;
    end
    chk("handshake0_seen", 64'(done[0]), 1);
    chk("handshake1_seen", 64'(done[1]), 1);
    for (int d = 0; d < 2; d++) begin
      iv[d]   = 1'b0;
      ordy[d] = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] w;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      iv[d]   = 1'b0;
      id[d]   = '0;
      ordy[d] = 1'b0;
`ifdef DES_SBOX_SEQ_ABORT_EN
      abort_s[d] = 1'b0;
`endif
    end
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    rst = 1'b0;
    @(negedge clk);
    chk("rdy_after_rst0", ir[0], 1);
    chk("rdy_after_rst1", ir[1], 1);

    // Directed words from the known DES results.
    txn(48'h0, 32'hEFA72C4D, 0, 1'b0);
    txn(48'hFFFFFFFFFFFF, 32'hD9CE3DCB, 0, 1'b1);
    // Backpressure: result held five cycles while in_valid keeps knocking.
    txn(48'h0, 32'hEFA72C4D, 5, 1'b1);

    // Random words against the model.
    for (int i = 0; i < 8; i++) begin
      w = rnd48();
      txn(w, ref_sub(w), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a transaction (cycle t+4).
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b1;
      id[d] = rnd48();
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) iv[d] = 1'b0;
    end
    chk("midop_busy0", bsy[0], 1);
    chk("midop_busy1", bsy[1], 1);
    rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rdy_after_midrst0", ir[0], 1);
    chk("rdy_after_midrst1", ir[1], 1);
    txn(48'h0, 32'hEFA72C4D, 0, 1'b0);

`ifdef DES_SBOX_SEQ_ABORT_EN
    // Abort pulsed in cycle t+3: back to IDLE at t+4, no result ever appears.
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      iv[d]   = 1'b1;
      id[d]   = 48'hFFFFFFFFFFFF;
      ordy[d] = 1'b1;
    end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) iv[d] = 1'b0;
    end
    for (int d = 0; d < 2; d++) abort_s[d] = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      abort_s[d] = 1'b0;
      chk($sformatf("abort_rdy%0d", d), ir[d], 1);
      chk($sformatf("abort_busy%0d", d), bsy[d], 0);
      chk($sformatf("abort_data%0d", d), od[d], 0);
    end
    for (int k = 0; k < 12; k++) begin
      for (int d = 0; d < 2; d++) chk($sformatf("abort_novalid%0d_%0d", d, k), ov[d], 0);
      @(negedge clk);
    end
    for (int d = 0; d < 2; d++) ordy[d] = 1'b0;
    txn(48'hFFFFFFFFFFFF, 32'hD9CE3DCB, 0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
